// File: rtl/main_bus_arbiter_if.sv
// Main-bus arbitration signals shared between the arbiter and the processor-side requesters.
// master: the arbiter; slave: requester/bus side driving req and AddrValid.
interface main_bus_arbiter_if #(
    parameter int unsigned NREQ = 4
) ();
    localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] req;
    logic            AddrValid;
    logic [NREQ-1:0] grant;
    logic [OW-1:0]   owner;
    logic            bus_busy;
    logic            timeout_err;

    modport master (
        input  req, AddrValid,
        output grant, owner, bus_busy, timeout_err
    );

    modport slave (
        output req, AddrValid,
        input  grant, owner, bus_busy, timeout_err
    );
endinterface

// File: rtl/main_bus_arbiter.sv
// Round-robin main-bus arbiter: one grant per transaction (address cycle + BEATS data beats),
// with a dead turnaround cycle between owners so AddrData never has two drivers.
module main_bus_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned BEATS   = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input logic                clk,
    input logic                resetN,
    main_bus_arbiter_if.master bus
);
    localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned IW = OW + 1;
    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {StIdle, StGrant, StBurst, StTurn} state_e;

    state_e          r_state, w_state_d;
    logic [OW-1:0]   r_owner, w_owner_d;
    logic [BW-1:0]   r_beat, w_beat_d;
    logic [7:0]      r_tmo, w_tmo_d;
    logic [NREQ-1:0] r_grant, w_grant_d;
    logic            w_found;
    logic [OW-1:0]   w_pick;
    logic [IW-1:0]   w_idx;
    logic            w_tmo_err;

    // Search starts one past the last owner; indices wrap modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_owner} + IW'(i + 1);
            if (w_idx >= IW'(NREQ)) begin
                w_idx = w_idx - IW'(NREQ);
            end
            if (!w_found && bus.req[w_idx[OW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[OW-1:0];
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_owner_d = r_owner;
        w_beat_d  = r_beat;
        w_tmo_d   = r_tmo;
        w_tmo_err = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_state_d = StGrant;
                    w_owner_d = w_pick;
                    w_tmo_d   = '0;
                end
            end
            StGrant: begin
                // Address strobe beats the timeout terminal count.
                if (bus.AddrValid) begin
                    w_state_d = StBurst;
                    w_beat_d  = '0;
                end else if (!bus.req[r_owner]) begin
                    w_state_d = StIdle;
                end else if (r_tmo == 8'(TIMEOUT - 1)) begin
                    w_tmo_err = 1'b1;
                    w_state_d = StTurn;
                end else begin
                    w_tmo_d = r_tmo + 8'd1;
                end
            end
            StBurst: begin
                if (r_beat == BW'(BEATS - 1)) begin
                    w_state_d = StTurn;
                end else begin
                    w_beat_d = r_beat + BW'(1);
                end
            end
            StTurn:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase

        w_grant_d = '0;
        if (w_state_d == StGrant || w_state_d == StBurst) begin
            w_grant_d[w_owner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= StIdle;
            r_owner <= OW'(NREQ - 1);
            r_beat  <= '0;
            r_tmo   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_d;
            r_owner <= w_owner_d;
            r_beat  <= w_beat_d;
            r_tmo   <= w_tmo_d;
            r_grant <= w_grant_d;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.owner       = r_owner;
    assign bus.bus_busy    = (r_state == StGrant) || (r_state == StBurst);
    assign bus.timeout_err = w_tmo_err;
endmodule

// File: tb/tb_main_bus_arbiter.sv
// Self-checking bench for main_bus_arbiter: directed vector table plus randomized traffic
// compared against a timestamp-based transaction model.
module tb_main_bus_arbiter;
    localparam int NREQ    = 4;
    localparam int BEATS   = 4;
    localparam int TIMEOUT = 8;

    logic clk    = 1'b0;
    logic resetN = 1'b0;

    main_bus_arbiter_if #(.NREQ(NREQ)) bus ();

    main_bus_arbiter #(
        .NREQ    (NREQ),
        .BEATS   (BEATS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit         rstn;
        logic [3:0] req;
        bit         av;
        logic [3:0] grant;
        bit         busy;
        bit         err;
        logic [1:0] owner;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit rn, input int rq, input bit av,
                                input int g, input bit b, input bit e, input int o);
        vec_t v;
        v.rstn  = rn;
        v.req   = 4'(rq);
        v.av    = av;
        v.grant = 4'(g);
        v.busy  = b;
        v.err   = e;
        v.owner = 2'(o);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Inputs change just after a rising edge; outputs are sampled mid-cycle.
    task automatic drive(input bit rn, input logic [3:0] rq, input bit av);
        resetN        = rn;
        bus.req       = rq;
        bus.AddrValid = av;
        #3;
    endtask

    // Reference model: a grant is described by its holder, the cycle it became visible,
    // and (once AddrValid is seen) the last cycle of its burst.
    int m_holder, m_last, m_start, m_end, m_idle_from, mc;
    bit m_addr;

    task automatic model_step(input bit rn, input logic [3:0] rq, input bit av,
                              output logic [3:0] eg, output logic [1:0] eo,
                              output bit eb, output bit ee);
        eg = '0;
        eb = 1'b0;
        ee = 1'b0;
        eo = 2'(m_last);
        if (!rn) begin
            m_holder    = -1;
            m_last      = NREQ - 1;
            m_idle_from = mc + 1;
            eo          = 2'(NREQ - 1);
        end else if (m_holder >= 0) begin
            eg[m_holder[1:0]] = 1'b1;
            eb = 1'b1;
            if (!m_addr) begin
                if (av) begin
                    m_addr = 1'b1;
                    m_end  = mc + BEATS;
                end else if (!rq[m_holder[1:0]]) begin
                    m_holder    = -1;
                    m_idle_from = mc + 1;
                end else if (mc - m_start == TIMEOUT - 1) begin
                    ee          = 1'b1;
                    m_holder    = -1;
                    m_idle_from = mc + 2;
                end
            end else if (mc == m_end) begin
                m_holder    = -1;
                m_idle_from = mc + 2;
            end
        end else if (mc >= m_idle_from) begin
            for (int i = 1; i <= NREQ; i++) begin
                int k;
                k = (m_last + i) % NREQ;
                if (m_holder < 0 && rq[k[1:0]]) begin
                    m_holder = k;
                    m_last   = k;
                    m_start  = mc + 1;
                    m_addr   = 1'b0;
                end
            end
        end
        mc++;
    endtask

    initial begin
        logic [3:0] rq, eg;
        logic [1:0] eo;
        bit         rn, av, eb, ee;

        bus.req       = '0;
        bus.AddrValid = 1'b0;
        resetN        = 1'b0;

        // Single request, address on the second grant cycle.
        add(1, 'b0001, 0, 'b0000, 0, 0, 3);
        add(1, 'b0001, 0, 'b0001, 1, 0, 0);
        add(1, 'b0001, 1, 'b0001, 1, 0, 0);
        for (int i = 0; i < BEATS; i++) add(1, 'b0000, 0, 'b0001, 1, 0, 0);
        add(1, 'b0000, 0, 'b0000, 0, 0, 0);
        // Withdrawal: no turnaround, requester re-granted straight from IDLE.
        add(1, 'b0010, 0, 'b0000, 0, 0, 0);
        add(1, 'b0000, 0, 'b0010, 1, 0, 1);
        add(1, 'b0010, 0, 'b0000, 0, 0, 1);
        add(1, 'b0000, 0, 'b0010, 1, 0, 1);
        // Timeout with requester 0 also waiting.
        add(1, 'b0100, 0, 'b0000, 0, 0, 1);
        for (int i = 0; i < TIMEOUT - 1; i++) add(1, 'b0101, 0, 'b0100, 1, 0, 2);
        add(1, 'b0101, 0, 'b0100, 1, 1, 2);
        add(1, 'b0101, 0, 'b0000, 0, 0, 2);
        add(1, 'b0001, 0, 'b0000, 0, 0, 2);
        // Grant to 0, then asynchronous reset during beat 2.
        add(1, 'b0001, 1, 'b0001, 1, 0, 0);
        add(1, 'b0000, 1, 'b0001, 1, 0, 0);
        add(1, 'b0000, 1, 'b0001, 1, 0, 0);
        add(0, 'b1000, 0, 'b0000, 0, 0, 3);
        add(1, 'b1000, 0, 'b0000, 0, 0, 3);
        add(1, 'b1000, 0, 'b1000, 1, 0, 3);
        // Burst immunity: req dropped and AddrValid held high through the beats.
        add(1, 'b1000, 1, 'b1000, 1, 0, 3);
        for (int i = 0; i < BEATS; i++) add(1, 'b0000, 1, 'b1000, 1, 0, 3);
        add(1, 'b0000, 0, 'b0000, 0, 0, 3);
        add(1, 'b0000, 0, 'b0000, 0, 0, 3);
        add(1, 'b0000, 0, 'b0000, 0, 0, 3);
        // Round-robin under continuous requests.
        for (int t = 0; t < 5; t++) begin
            int k, p;
            k = t % NREQ;
            p = (t == 0) ? 3 : (t - 1) % NREQ;
            add(1, 'b1111, 0, 'b0000, 0, 0, p);
            add(1, 'b1111, 1, 1 << k, 1, 0, k);
            for (int i = 0; i < BEATS; i++) add(1, 'b1111, 0, 1 << k, 1, 0, k);
            add(1, 'b1111, 0, 'b0000, 0, 0, k);
        end

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rstn, vecs[i].req, vecs[i].av);
            chk($sformatf("vec%0d grant", i), 8'(bus.grant), 8'(vecs[i].grant));
            chk($sformatf("vec%0d busy", i), 8'(bus.bus_busy), 8'(vecs[i].busy));
            chk($sformatf("vec%0d timeout_err", i), 8'(bus.timeout_err), 8'(vecs[i].err));
            chk($sformatf("vec%0d owner", i), 8'(bus.owner), 8'(vecs[i].owner));
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the model.
        mc       = 0;
        m_holder = -1;
        m_last   = NREQ - 1;
        rq       = '0;
        for (int c = 0; c < 800; c++) begin
            rn = (c < 2) ? 1'b0 : ($urandom_range(0, 249) != 0);
            rq = rq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            av = ($urandom_range(0, 3) == 0);
            drive(rn, rq, av);
            model_step(rn, rq, av, eg, eo, eb, ee);
            chk($sformatf("rnd%0d grant", c), 8'(bus.grant), 8'(eg));
            chk($sformatf("rnd%0d owner", c), 8'(bus.owner), 8'(eo));
            chk($sformatf("rnd%0d busy", c), 8'(bus.bus_busy), 8'(eb));
            chk($sformatf("rnd%0d timeout_err", c), 8'(bus.timeout_err), 8'(ee));
            chk($sformatf("rnd%0d onehot", c), 8'($countones(bus.grant) <= 1), 8'd1);
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
